// File: rtl/id_ex_alu_issue.sv
// rtl/id_ex_alu_issue.sv - ID/EX pipeline register with ALU control decode and illegal-instruction tracking
// One-cycle issue stage: flush > stall > load, rejected instructions become bubbles and are counted.
module id_ex_alu_issue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm16,
  input  logic        stall,
  input  logic        flush,
  output logic        in_ready,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [2:0]  ex_ctrl,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SPEC2 = 6'h1C;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_MUL  = 6'h02;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b111;

  logic        dec_ok;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_ctrl;
  logic        dec_rw;
  logic        dec_mr;
  logic        dec_mw;
  logic [31:0] imm_sx;

  assign in_ready = !stall;
  assign imm_sx   = {{16{imm16[15]}}, imm16};

  always_comb begin
    dec_ok   = 1'b0;
    dec_a    = rs_data;
    dec_b    = rt_data;
    dec_ctrl = ALU_ADD;
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_rw = 1'b1;
        case (funct)
          FN_ADD:  begin dec_ok = 1'b1; dec_ctrl = ALU_ADD; end
          FN_SUB:  begin dec_ok = 1'b1; dec_ctrl = ALU_SUB; end
          FN_OR:   begin dec_ok = 1'b1; dec_ctrl = ALU_OR;  end
          FN_XOR:  begin dec_ok = 1'b1; dec_ctrl = ALU_XOR; end
          FN_SLLV: begin
            // shift amount comes from rs, value being shifted from rt
            dec_ok   = 1'b1;
            dec_ctrl = ALU_SLL;
            dec_a    = rt_data;
            dec_b    = rs_data;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      OP_SPEC2: begin
        dec_ok   = (funct == FN_MUL);
        dec_ctrl = ALU_MUL;
        dec_rw   = 1'b1;
      end
      OP_ADDI: begin
        dec_ok = 1'b1;
        dec_b  = imm_sx;
        dec_rw = 1'b1;
      end
      OP_LW: begin
        dec_ok = 1'b1;
        dec_b  = imm_sx;
        dec_rw = 1'b1;
        dec_mr = 1'b1;
      end
      OP_SW: begin
        dec_ok = 1'b1;
        dec_b  = imm_sx;
        dec_mw = 1'b1;
      end
      OP_BEQ: begin
        dec_ok   = 1'b1;
        dec_ctrl = ALU_SUB;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_A         <= 32'd0;
      ex_B         <= 32'd0;
      ex_ctrl      <= 3'd0;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      illegal      <= 1'b0;
      illegal_cnt  <= 8'd0;
    end else if (flush) begin
      ex_A         <= 32'd0;
      ex_B         <= 32'd0;
      ex_ctrl      <= 3'd0;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      illegal      <= 1'b0;
    end else if (stall) begin
      // payload holds; the illegal pulse must still drop after one cycle
      illegal <= 1'b0;
    end else if (in_valid && dec_ok) begin
      ex_A         <= dec_a;
      ex_B         <= dec_b;
      ex_ctrl      <= dec_ctrl;
      ex_valid     <= 1'b1;
      ex_reg_write <= dec_rw;
      ex_mem_read  <= dec_mr;
      ex_mem_write <= dec_mw;
      illegal      <= 1'b0;
    end else begin
      ex_A         <= 32'd0;
      ex_B         <= 32'd0;
      ex_ctrl      <= 3'd0;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      illegal      <= in_valid;
      if (in_valid && (illegal_cnt != 8'hFF)) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb/tb_id_ex_alu_issue.sv - self-checking bench for id_ex_alu_issue
// Table-driven reference model of the issue stage, directed and randomized scenarios.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm16;
  logic        stall;
  logic        flush;
  logic        in_ready;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [2:0]  ex_ctrl;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16), .stall(stall), .flush(flush),
    .in_ready(in_ready), .ex_A(ex_A), .ex_B(ex_B), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  // Instruction table: operand swap / immediate select / flags per legal encoding.
  typedef struct {
    logic [5:0] op;
    logic       fn_care;
    logic [5:0] fn;
    logic [2:0] ctrl;
    logic       swap;
    logic       use_imm;
    logic       rw;
    logic       mr;
    logic       mw;
  } rule_t;

  rule_t rules [10];

  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctrl;
  logic        m_v, m_rw, m_mr, m_mw, m_ill;
  int          m_cnt;

  wire [79:0] got = {ex_A, ex_B, ex_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, illegal, illegal_cnt};

  function automatic logic [79:0] model_vec();
    logic [7:0] c;
    c = 8'(m_cnt);
    return {m_a, m_b, m_ctrl, m_v, m_rw, m_mr, m_mw, m_ill, c};
  endfunction

  function automatic void set_rule(input int i, input logic [5:0] op, input logic fc, input logic [5:0] fn,
                                   input logic [2:0] ctrl, input logic sw, input logic im,
                                   input logic rw, input logic mr, input logic mw);
    rules[i].op = op; rules[i].fn_care = fc; rules[i].fn = fn; rules[i].ctrl = ctrl;
    rules[i].swap = sw; rules[i].use_imm = im; rules[i].rw = rw; rules[i].mr = mr; rules[i].mw = mw;
  endfunction

  function automatic void model_bubble();
    m_a = 0; m_b = 0; m_ctrl = 0; m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0;
  endfunction

  function automatic void model_reset();
    model_bubble();
    m_ill = 0;
    m_cnt = 0;
  endfunction

  // Apply one rising edge to the model using the inputs currently presented.
  function automatic void model_edge();
    int hit;
    hit = -1;
    if (flush) begin
      model_bubble(); m_ill = 0;
    end else if (stall) begin
      m_ill = 0;
    end else if (!in_valid) begin
      model_bubble(); m_ill = 0;
    end else begin
      for (int i = 0; i < 10; i++)
        if (hit < 0 && rules[i].op == opcode && (!rules[i].fn_care || rules[i].fn == funct)) hit = i;
      if (hit < 0) begin
        model_bubble(); m_ill = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else begin
        m_v = 1; m_ill = 0;
        m_ctrl = rules[hit].ctrl;
        m_rw = rules[hit].rw; m_mr = rules[hit].mr; m_mw = rules[hit].mw;
        m_a = rules[hit].swap ? rt_data : rs_data;
        m_b = rules[hit].use_imm ? {{16{imm16[15]}}, imm16} : (rules[hit].swap ? rs_data : rt_data);
      end
    end
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, input logic v, input logic st, input logic fl);
    opcode = op; funct = fn; rs_data = rs; rt_data = rt; imm16 = imm;
    in_valid = v; stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    drive(6'h0, 6'h0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    drive(6'h0, 6'h20, 32'h11, 32'h22, 0, 1, 0, 0);
    #2;
    total++;
    if (got !== 80'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", got, 80'd0);
    end
    @(posedge clk); #1;
    total++;
    if (got !== 80'd0) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", got, 80'd0);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL in_ready_reset got=%b exp=1", in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 1, 0, 0);
    step();
    total++;
    if ({ex_ctrl, ex_A, ex_B, ex_valid, ex_reg_write} !== {3'b000, 32'd5, 32'd7, 1'b1, 1'b1}) begin
      bad++; $display("FAIL add got ctrl=%b A=%0d B=%0d v=%b rw=%b exp ctrl=000 A=5 B=7 v=1 rw=1",
                      ex_ctrl, ex_A, ex_B, ex_valid, ex_reg_write);
    end
    total++;
    if (got !== model_vec()) begin
      bad++; $display("FAIL add_model got=%h exp=%h", got, model_vec());
    end
  endtask

  task automatic test_lw_sw();
    drive(6'h23, 6'h3F, 32'h100, 32'h55, 16'hFFFC, 1, 0, 0);
    step();
    total++;
    if ({ex_ctrl, ex_A, ex_B, ex_mem_read, ex_mem_write, ex_reg_write} !== {3'b000, 32'h100, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL lw got ctrl=%b A=%h B=%h mr=%b mw=%b rw=%b", ex_ctrl, ex_A, ex_B, ex_mem_read, ex_mem_write, ex_reg_write);
    end
    drive(6'h2B, 6'h00, 32'h100, 32'h55, 16'hFFFC, 1, 0, 0);
    step();
    total++;
    if ({ex_ctrl, ex_B, ex_mem_read, ex_mem_write, ex_reg_write} !== {3'b000, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sw got ctrl=%b B=%h mr=%b mw=%b rw=%b", ex_ctrl, ex_B, ex_mem_read, ex_mem_write, ex_reg_write);
    end
    drive(6'h08, 6'h00, 32'h10, 32'h0, 16'h7FFF, 1, 0, 0);
    step();
    total++;
    if (got !== model_vec()) begin
      bad++; $display("FAIL addi got=%h exp=%h", got, model_vec());
    end
  endtask

  task automatic test_sllv_mul();
    drive(6'h00, 6'h04, 32'd3, 32'd1, 16'h0, 1, 0, 0);
    step();
    total++;
    if ({ex_ctrl, ex_A, ex_B} !== {3'b010, 32'd1, 32'd3}) begin
      bad++; $display("FAIL sllv got ctrl=%b A=%0d B=%0d exp ctrl=010 A=1 B=3", ex_ctrl, ex_A, ex_B);
    end
    drive(6'h1C, 6'h02, 32'd6, 32'd9, 16'h0, 1, 0, 0);
    step();
    total++;
    if ({ex_ctrl, ex_A, ex_B, ex_reg_write} !== {3'b011, 32'd6, 32'd9, 1'b1}) begin
      bad++; $display("FAIL mul got ctrl=%b A=%0d B=%0d rw=%b", ex_ctrl, ex_A, ex_B, ex_reg_write);
    end
    drive(6'h04, 6'h00, 32'd8, 32'd8, 16'h0, 1, 0, 0);
    step();
    total++;
    if (got !== model_vec()) begin
      bad++; $display("FAIL beq got=%h exp=%h", got, model_vec());
    end
  endtask

  task automatic test_stall_flush();
    drive(6'h00, 6'h22, 32'd10, 32'd3, 16'h0, 1, 0, 0);
    step();
    drive(6'h00, 6'h26, 32'hAA, 32'hBB, 16'h0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({ex_ctrl, ex_A, ex_B, ex_valid, ex_reg_write, in_ready} !== {3'b111, 32'd10, 32'd3, 1'b1, 1'b1, 1'b0}) begin
        bad++; $display("FAIL stall_hold[%0d] got ctrl=%b A=%0d B=%0d v=%b ready=%b exp ctrl=111 A=10 B=3 v=1 ready=0",
                        i, ex_ctrl, ex_A, ex_B, ex_valid, in_ready);
      end
    end
    drive(6'h00, 6'h26, 32'hAA, 32'hBB, 16'h0, 1, 1, 1);
    step();
    total++;
    if (got !== 80'(illegal_cnt_expect())) begin
      bad++; $display("FAIL stall_flush_bubble got=%h exp=%h", got, 80'(illegal_cnt_expect()));
    end
  endtask

  function automatic logic [7:0] illegal_cnt_expect();
    return 8'(m_cnt);
  endfunction

  task automatic test_illegal_saturate();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(6'h3F, 6'($urandom), $urandom, $urandom, 16'($urandom), 1, 0, 0);
      step();
      total++;
      if (illegal !== 1'b1 || ex_valid !== 1'b0 || got !== model_vec()) begin
        bad++; $display("FAIL illegal_pulse[%0d] got=%h exp=%h", i, got, model_vec());
      end
      if (i == 3) begin
        drive(6'h3F, 6'h00, 32'd1, 32'd2, 16'h0, 1, 1, 0);
        step();
        total++;
        if (illegal !== 1'b0 || illegal_cnt !== 8'd4) begin
          bad++; $display("FAIL illegal_stall got ill=%b cnt=%0d exp ill=0 cnt=4", illegal, illegal_cnt);
        end
      end
    end
    total++;
    if (illegal_cnt !== 8'd255) begin
      bad++; $display("FAIL illegal_saturate got=%0d exp=255", illegal_cnt);
    end
    drive(6'h3F, 6'h00, 32'd1, 32'd2, 16'h0, 1, 0, 1);
    step();
    total++;
    if (illegal !== 1'b0 || illegal_cnt !== 8'd255 || ex_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_flush got ill=%b cnt=%0d v=%b exp ill=0 cnt=255 v=0", illegal, illegal_cnt, ex_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [5:0] op, fn;
      k = int'($urandom_range(0, 12));
      if (k < 10) begin
        op = rules[k].op;
        fn = rules[k].fn_care ? rules[k].fn : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      drive(op, fn, $urandom, $urandom, 16'($urandom), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      step();
      total++;
      if (got !== model_vec() || in_ready !== !stall) begin
        bad++; $display("FAIL random[%0d] op=%h fn=%h got=%h exp=%h ready=%b", i, op, fn, got, model_vec(), in_ready);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(6'h3F, 6'h00, 0, 0, 0, 1, 0, 0);
    step();
    drive(6'h00, 6'h25, 32'hF0, 32'h0F, 16'h0, 1, 0, 0);
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (got !== 80'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", got, 80'd0);
    end
    @(posedge clk); #1;
    total++;
    if (got !== 80'd0) begin
      bad++; $display("FAIL reset_discard got=%h exp=%h", got, 80'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total++;
    if ({ex_ctrl, ex_A, ex_B, ex_valid} !== {3'b100, 32'hF0, 32'h0F, 1'b1} || got !== model_vec()) begin
      bad++; $display("FAIL first_load got=%h exp=%h", got, model_vec());
    end
  endtask

  initial begin
    set_rule(0, 6'h00, 1, 6'h20, 3'b000, 0, 0, 1, 0, 0);
    set_rule(1, 6'h00, 1, 6'h22, 3'b111, 0, 0, 1, 0, 0);
    set_rule(2, 6'h00, 1, 6'h25, 3'b100, 0, 0, 1, 0, 0);
    set_rule(3, 6'h00, 1, 6'h26, 3'b001, 0, 0, 1, 0, 0);
    set_rule(4, 6'h00, 1, 6'h04, 3'b010, 1, 0, 1, 0, 0);
    set_rule(5, 6'h1C, 1, 6'h02, 3'b011, 0, 0, 1, 0, 0);
    set_rule(6, 6'h08, 0, 6'h00, 3'b000, 0, 1, 1, 0, 0);
    set_rule(7, 6'h23, 0, 6'h00, 3'b000, 0, 1, 1, 1, 0);
    set_rule(8, 6'h2B, 0, 6'h00, 3'b000, 0, 1, 0, 0, 1);
    set_rule(9, 6'h04, 0, 6'h00, 3'b111, 0, 0, 0, 0, 0);

    test_reset();
    test_add();
    test_lw_sw();
    test_sllv_mul();
    test_stall_flush();
    test_illegal_saturate();
    test_random();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, decode stage presents an instruction.
REQ-004 SHALL have ports opcode and funct, input, 6 each, instruction fields [31:26] and [5:0].
REQ-005 SHALL have ports rs_data and rt_data, input, 32 each, register-file read values.
REQ-006 SHALL have port imm16, input, 16, instruction field [15:0].
REQ-007 SHALL have ports stall and flush, input, 1 each, hazard-unit hold and kill.
REQ-008 SHALL have port in_ready, output, 1, equal to !stall (combinational).
REQ-009 SHALL have ports ex_A and ex_B, output, 32 each, registered ALU operands.
REQ-010 SHALL have port ex_ctrl, output, 3, registered ALU Control_Input code.
REQ-011 SHALL have ports ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, output, 1 each, registered.
REQ-012 SHALL have port illegal, output, 1, registered one-cycle pulse per rejected instruction.
REQ-013 SHALL have port illegal_cnt, output, 8, saturating count of rejected instructions.

Function
REQ-014 SHALL decode opcode 0x00 by funct: 0x20 add->000, 0x22 sub->111, 0x25 or->100, 0x26 xor->001, 0x04 sllv->010; ex_A=rs_data, ex_B=rt_data, except sllv ex_A=rt_data, ex_B=rs_data; ex_reg_write=1.
REQ-015 SHALL decode opcode 0x1C with funct 0x02 (mul) to 011, ex_A=rs_data, ex_B=rt_data, ex_reg_write=1.
REQ-016 SHALL decode addi 0x08 and lw 0x23 to 000 with ex_B = sign-extended imm16; ex_reg_write=1; lw also ex_mem_read=1.
REQ-017 SHALL decode sw 0x2B to 000 with ex_B = sign-extended imm16, ex_mem_write=1, ex_reg_write=0.
REQ-018 SHALL decode beq 0x04 to 111, ex_A=rs_data, ex_B=rt_data, all write/mem flags 0.
REQ-019 SHALL treat every other opcode/funct pair as illegal: load bubble (ex_valid=0, ex_ctrl=000, operands 0, flags 0) and set illegal=1 for exactly one cycle.
REQ-020 SHALL, per edge, apply priority flush > stall > load: flush loads bubble; stall holds all registered outputs unchanged; otherwise in_valid=1 loads decode, in_valid=0 loads bubble.
REQ-021 SHALL latency be one cycle: instruction accepted at edge N appears on ex_* after edge N.
REQ-022 SHALL, when flush=1 with illegal input, load bubble and NOT pulse illegal nor increment illegal_cnt.
REQ-023 SHALL, when stall=1 with illegal input, not pulse illegal nor count (instruction not accepted); illegal deasserts after one cycle even under stall.
REQ-024 SHALL increment illegal_cnt by 1 per accepted illegal instruction, saturating at 255 (no wrap).
REQ-025 SHALL force bubble outputs to have all flags 0 regardless of prior contents.

Reset
REQ-026 SHALL, on reset_n=0, immediately clear ex_A, ex_B, ex_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, illegal and illegal_cnt to 0, independent of clk.
REQ-027 SHALL discard any instruction in flight when reset asserts mid-operation; first load occurs on first rising edge with reset_n=1.

Verification
REQ-028 SHALL cover: add, rs=5, rt=7 -> next cycle ex_ctrl=000, ex_A=5, ex_B=7, ex_valid=1, ex_reg_write=1.
REQ-029 SHALL cover: lw imm16=0xFFFC, rs=0x100 -> ex_ctrl=000, ex_B=0xFFFFFFFC, ex_mem_read=1; sw same -> ex_mem_write=1, ex_reg_write=0.
REQ-030 SHALL cover: sllv rs=3, rt=1 -> ex_ctrl=010, ex_A=1, ex_B=3; mul -> ex_ctrl=011.
REQ-031 SHALL cover: sub issued then stall=1 for 3 cycles with new xor on inputs -> outputs hold sub values, in_ready=0; stall+flush same cycle -> bubble.
REQ-032 SHALL cover: opcode 0x3F accepted 256 times -> illegal pulses each time, illegal_cnt stops at 255; illegal with flush -> no pulse, count unchanged.
REQ-033 SHALL cover: reset_n low mid-stream between edges -> all outputs 0 immediately, illegal_cnt=0.
